// File: rtl/timer_peripheral.sv
// Memory-mapped 32-bit interval timer (TH reload, TL up-counter, TCON control/status) with a level IRQ.
// Define TIMER_PRESCALE_EN to add the PSC prescaler register at base+12.
module timer_peripheral #(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        IRQ
);

   // Bus protocol: no handshake. A strobe with an aligned in-window address completes
   // in its own cycle: reads are combinational, writes take effect on the rising edge.
   logic [31:0] offset;
   logic        hit;
   logic        wr_th, wr_tl, wr_tcon;

   assign offset  = Addr - BASE_ADDR;
   assign hit     = (offset < 32'd16) && (offset[1:0] == 2'b00);
   assign wr_th   = MemWr && hit && (offset[3:2] == 2'd0);
   assign wr_tl   = MemWr && hit && (offset[3:2] == 2'd1);
   assign wr_tcon = MemWr && hit && (offset[3:2] == 2'd2);

   logic [31:0] th;
   logic [31:0] tl;
   logic        en;
   logic        ie;
   logic        st;
   logic        tick;
   logic        ovf;

`ifdef TIMER_PRESCALE_EN
   logic [15:0] psc;
   logic [15:0] pc;
   logic        wr_psc;

   assign wr_psc = MemWr && hit && (offset[3:2] == 2'd3);
   assign tick   = en && (pc == psc);

   // Any PSC write restarts the prescale period from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psc <= 16'd0;
         pc  <= 16'd0;
      end else if (wr_psc) begin
         psc <= WriteData[15:0];
         pc  <= 16'd0;
      end else if (en) begin
         pc  <= (pc == psc) ? 16'd0 : pc + 16'd1;
      end
   end
`else
   assign tick = en;
`endif

   // A TL write wins over the tick, so that edge is neither an increment nor an overflow.
   assign ovf = tick && (tl == 32'hFFFF_FFFF) && !wr_tl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th <= 32'd0;
         tl <= 32'd0;
      end else begin
         if (wr_th)
            th <= WriteData;
         if (wr_tl)
            tl <= WriteData;
         else if (ovf)
            tl <= th;
         else if (tick)
            tl <= tl + 32'd1;
      end
   end

   // Overflow setting ST beats a same-edge acknowledge so no interrupt is lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en <= 1'b0;
         ie <= 1'b0;
         st <= 1'b0;
      end else begin
         if (wr_tcon) begin
            en <= WriteData[0];
            ie <= WriteData[1];
            st <= WriteData[2] | (ovf & ie);
         end else if (ovf && ie) begin
            st <= 1'b1;
         end
      end
   end

   assign IRQ = ie & st;

   always_comb begin
      ReadData = 32'd0;
      if (MemRd && hit) begin
         case (offset[3:2])
            2'd0:    ReadData = th;
            2'd1:    ReadData = tl;
            2'd2:    ReadData = {29'd0, st, ie, en};
`ifdef TIMER_PRESCALE_EN
            2'd3:    ReadData = {16'd0, psc};
`endif
            default: ReadData = 32'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_peripheral.sv
// Self-checking bench for timer_peripheral: directed scenarios plus randomized counting
// checked against a closed-form model of tick/overflow arithmetic.
module tb_timer_peripheral;

   localparam logic [31:0] A_TH   = 32'h4000_0000;
   localparam logic [31:0] A_TL   = 32'h4000_0004;
   localparam logic [31:0] A_TCON = 32'h4000_0008;
   localparam logic [31:0] A_PSC  = 32'h4000_000C;

   logic        clk;
   logic        reset;
   logic        MemRd;
   logic        MemWr;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        IRQ;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   timer_peripheral #(.BASE_ADDR(32'h4000_0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemRd     (MemRd),
      .MemWr     (MemWr),
      .Addr      (Addr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .IRQ       (IRQ)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // driver tasks: writes take exactly one rising edge and return 1 time unit after it
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      Addr      = a;
      WriteData = d;
      MemWr     = 1'b1;
      @(posedge clk);
      #1;
      MemWr     = 1'b0;
      Addr      = 32'd0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      Addr  = a;
      MemRd = 1'b1;
      #1;
      d     = ReadData;
      MemRd = 1'b0;
      Addr  = 32'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // reference model: TL after n ticks from tl0, and how many overflows happened
   function automatic void model_count(input logic [31:0] th, input logic [31:0] tl0,
                                       input longint n, output logic [31:0] tl_o,
                                       output longint ovf);
      longint first, per, rest;
      first = 64'sh1_0000_0000 - longint'({32'd0, tl0});
      per   = 64'sh1_0000_0000 - longint'({32'd0, th});
      if (n < first) begin
         tl_o = tl0 + 32'(n);
         ovf  = 0;
      end else begin
         rest = n - first;
         ovf  = 1 + rest / per;
         tl_o = th + 32'(rest % per);
      end
   endfunction

   task automatic test_reset();
      logic [31:0] rd;
      bus_read(A_TH, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_th: got %h expected %h", rd, 32'd0); end
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_tl: got %h expected %h", rd, 32'd0); end
      bus_read(A_TCON, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_tcon: got %h expected %h", rd, 32'd0); end
      n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", IRQ); end
      bus_write(A_TL, 32'h1234);
      bus_write(A_TCON, 32'd1);
      idle(3);
      #2 reset = 1'b0;
      #1;
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL midreset_tl: got %h expected %h", rd, 32'd0); end
      bus_read(A_TCON, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL midreset_tcon: got %h expected %h", rd, 32'd0); end
      n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b expected 0", IRQ); end
      @(posedge clk);
      #1 reset = 1'b1;
      idle(5);
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL postreset_tl_frozen: got %h expected %h", rd, 32'd0); end
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH, 32'hFFFF_FFFC);
      bus_write(A_TL, 32'hFFFF_FFFC);
      bus_write(A_TCON, 32'd3);
      for (int k = 1; k <= 3; k++) begin
         idle(1);
         bus_read(A_TL, rd);
         n_checks++; if (rd !== 32'hFFFF_FFFC + 32'(k)) begin n_fail++; $display("FAIL ovf_count_%0d: got %h expected %h", k, rd, 32'hFFFF_FFFC + 32'(k)); end
      end
      idle(1);
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL ovf_reload: got %h expected %h", rd, 32'hFFFF_FFFC); end
      bus_read(A_TCON, rd);
      n_checks++; if (rd !== 32'd7) begin n_fail++; $display("FAIL ovf_tcon: got %h expected %h", rd, 32'd7); end
      n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ovf_irq: got %b expected 1", IRQ); end
   endtask

   // continues from the overflow left by test_overflow (TL=FFFFFFFC, IRQ high)
   task automatic test_ack();
      logic [31:0] rd;
      bus_write(A_TCON, 32'd3);
      n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL ack_irq_low: got %b expected 0", IRQ); end
      bus_read(A_TCON, rd);
      n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL ack_tcon: got %h expected %h", rd, 32'd3); end
      idle(2);
      n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL ack_irq_before_next: got %b expected 0", IRQ); end
      idle(1);
      n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ack_irq_reraised: got %b expected 1", IRQ); end
   endtask

   task automatic test_coincide();
      logic [31:0] rd;
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH, 32'hFFFF_FFF0);
      bus_write(A_TL, 32'hFFFF_FFFD);
      bus_write(A_TCON, 32'd3);
      // TL: FE, FF, then the acknowledging write lands on the overflow edge
      idle(2);
      bus_write(A_TCON, 32'd3);
      bus_read(A_TCON, rd);
      n_checks++; if (rd !== 32'd7) begin n_fail++; $display("FAIL coincide_st_kept: got %h expected %h", rd, 32'd7); end
      n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL coincide_irq: got %b expected 1", IRQ); end
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL coincide_reload: got %h expected %h", rd, 32'hFFFF_FFF0); end
      bus_write(A_TL, 32'h10);
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'h10) begin n_fail++; $display("FAIL tl_write_wins: got %h expected %h", rd, 32'h10); end
      idle(1);
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'h11) begin n_fail++; $display("FAIL tl_after_write: got %h expected %h", rd, 32'h11); end
   endtask

   task automatic test_ie_en();
      logic [31:0] rd;
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH, 32'd0);
      bus_write(A_TL, 32'hFFFF_FFFF);
      bus_write(A_TCON, 32'd3);
      idle(1);
      n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ie_first_irq: got %b expected 1", IRQ); end
      bus_write(A_TCON, 32'd5);
      n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL ie_cleared_irq: got %b expected 0", IRQ); end
      bus_read(A_TCON, rd);
      n_checks++; if (rd !== 32'd5) begin n_fail++; $display("FAIL ie_cleared_st_held: got %h expected %h", rd, 32'd5); end
      bus_write(A_TCON, 32'd7);
      n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ie_reset_irq: got %b expected 1", IRQ); end
      bus_write(A_TCON, 32'd6);
      idle(5);
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL en_freeze_tl: got %h expected %h", rd, 32'd3); end
      bus_read(A_TCON, rd);
      n_checks++; if (rd !== 32'd6) begin n_fail++; $display("FAIL en_freeze_tcon: got %h expected %h", rd, 32'd6); end
      n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL en_freeze_irq: got %b expected 1", IRQ); end
   endtask

   task automatic test_decode();
      logic [31:0] rd;
      bus_write(A_TCON, 32'd0);
      bus_write(A_TH, 32'hA5A5_A5A5);
      bus_write(A_TL, 32'h1234_5678);
      bus_write(32'h4000_0010, $urandom);
      bus_write(32'h4000_0006, $urandom);
      bus_write(32'h4000_0009, $urandom);
      bus_write(32'h3FFF_FFFC, $urandom);
      bus_read(A_TH, rd);
      n_checks++; if (rd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL decode_th_kept: got %h expected %h", rd, 32'hA5A5_A5A5); end
      bus_read(A_TL, rd);
      n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL decode_tl_kept: got %h expected %h", rd, 32'h1234_5678); end
      bus_read(A_TCON, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL decode_tcon_kept: got %h expected %h", rd, 32'd0); end
      bus_read(32'h4000_0010, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL decode_miss_read: got %h expected %h", rd, 32'd0); end
      bus_read(32'h4000_0006, rd);
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL decode_unaligned_read: got %h expected %h", rd, 32'd0); end
      Addr = A_TH;
      MemRd = 1'b0;
      #1;
      n_checks++; if (ReadData !== 32'd0) begin n_fail++; $display("FAIL decode_no_memrd: got %h expected %h", ReadData, 32'd0); end
      // read and write of the same register in one cycle returns the old value
      WriteData = 32'h1111_2222;
      MemRd = 1'b1;
      MemWr = 1'b1;
      #1;
      n_checks++; if (ReadData !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL rw_same_cycle_old: got %h expected %h", ReadData, 32'hA5A5_A5A5); end
      @(posedge clk);
      #1;
      MemRd = 1'b0;
      MemWr = 1'b0;
      bus_read(A_TH, rd);
      n_checks++; if (rd !== 32'h1111_2222) begin n_fail++; $display("FAIL rw_same_cycle_new: got %h expected %h", rd, 32'h1111_2222); end
      bus_write(A_PSC, 32'hFFFF_0003);
      bus_read(A_PSC, rd);
`ifdef TIMER_PRESCALE_EN
      n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL psc_readback: got %h expected %h", rd, 32'h3); end
      bus_write(A_PSC, 32'd0);
`else
      n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL psc_unmapped: got %h expected %h", rd, 32'd0); end
`endif
   endtask

`ifdef TIMER_PRESCALE_EN
   task automatic test_prescale();
      logic [31:0] rd;
      bus_write(A_TCON, 32'd0);
      bus_write(A_PSC, 32'd2);
      bus_write(A_TL, 32'd0);
      bus_write(A_TCON, 32'd1);
      for (int k = 1; k <= 9; k++) begin
         idle(1);
         bus_read(A_TL, rd);
         n_checks++; if (rd !== 32'(k / 3)) begin n_fail++; $display("FAIL prescale_tl_%0d: got %h expected %h", k, rd, 32'(k / 3)); end
      end
      bus_read(A_PSC, rd);
      n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL prescale_psc_read: got %h expected %h", rd, 32'd2); end
      bus_write(A_TCON, 32'd0);
      bus_write(A_PSC, 32'd0);
   endtask
`endif

   task automatic test_random();
      logic [31:0] th, tl0, tl_exp, rd, e;
      logic        ie;
      int          psc_eff, n;
      longint      ovf;
      for (int it = 0; it < 12; it++) begin
         th  = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
         tl0 = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
         ie  = 1'($urandom_range(0, 1));
         n   = $urandom_range(0, 60);
`ifdef TIMER_PRESCALE_EN
         psc_eff = $urandom_range(0, 3);
`else
         psc_eff = 0;
`endif
         bus_write(A_TCON, 32'd0);
         bus_write(A_PSC, 32'(psc_eff));
         bus_write(A_TH, th);
         bus_write(A_TL, tl0);
         bus_write(A_TCON, {30'd0, ie, 1'b1});
         idle(n);
         model_count(th, tl0, longint'(n / (psc_eff + 1)), tl_exp, ovf);
         exp_q.push_back(tl_exp);
         exp_q.push_back({29'd0, ie && (ovf > 0), ie, 1'b1});
         bus_read(A_TL, rd);
         e = exp_q.pop_front();
         n_checks++; if (rd !== e) begin n_fail++; $display("FAIL random_tl_%0d: got %h expected %h", it, rd, e); end
         bus_read(A_TCON, rd);
         e = exp_q.pop_front();
         n_checks++; if (rd !== e) begin n_fail++; $display("FAIL random_tcon_%0d: got %h expected %h", it, rd, e); end
         n_checks++; if (IRQ !== e[2]) begin n_fail++; $display("FAIL random_irq_%0d: got %b expected %b", it, IRQ, e[2]); end
      end
      bus_write(A_TCON, 32'd0);
      bus_write(A_PSC, 32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      MemRd     = 1'b0;
      MemWr     = 1'b0;
      Addr      = 32'd0;
      WriteData = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      test_reset();
      test_overflow();
      test_ack();
      test_coincide();
      test_ie_en();
      test_decode();
`ifdef TIMER_PRESCALE_EN
      test_prescale();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_peripheral.md
# timer_peripheral

Memory-mapped 32-bit interval timer that generates the `IRQ` request consumed by the CPU control decoder. It sits on the data-memory bus next to the data RAM, decoding its own address window, and raises `IRQ` when the low counter overflows with interrupts enabled. The interrupt handler reads and clears status through ordinary `lw`/`sw`. Software-visible registers are TH (reload), TL (count) and TCON (control/status).

## Interface
- `BASE_ADDR`, 32'h4000_0000: byte address of TH; TL = base+4, TCON = base+8, PSC = base+12.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `MemRd`  in  1  bus read strobe, same cycle as `Addr`.
- `MemWr`  in  1  bus write strobe, sampled on the rising edge.
- `Addr`  in  32  byte address; only word-aligned hits inside the window are decoded.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load data, combinational.
- `IRQ`  out  1  interrupt request, level.

## Operation
- Registers:
  - TH[31:0]: reload value.
  - TL[31:0]: up-counter.
  - TCON[2:0]:
    - bit0 `EN`: count enable.
    - bit1 `IE`: interrupt enable.
    - bit2 `ST`: status.
- Reset value of every register, internal prescale counter, `ReadData` and `IRQ` is 0.
- Tick: `tick` = `EN` && prescaler expiry. Without prescaler, `tick` = `EN`.
- On tick with TL != 32'hFFFF_FFFF: TL <= TL + 1.
- On tick with TL == 32'hFFFF_FFFF (overflow):
  - TL <= TH.
  - If `IE`, `ST` <= 1.
  - Period = 2^32 − TH ticks.
- `IRQ` = `IE` & `ST`, driven from registers and free of decode glitches.
- Writes (`MemWr` and address hit):
  - TH/TL take `WriteData` entirely.
  - TCON takes `WriteData[2:0]`. Writing `ST`=0 acknowledges the interrupt.
- Reads: if `MemRd` and hit, `ReadData` = register, zero-extended. Otherwise `ReadData` = 0.
- Misses or unaligned addresses (`Addr[1:0]` != 0): ignored; read as 0.
- Simultaneous events, same edge:
  - Software write to TL vs. tick: the write wins; no increment.
  - Software write of TCON with `ST`=0 vs. overflow setting `ST`: overflow wins, so the interrupt is not lost. `EN`/`IE` still take written values.
  - Write to TH vs. overflow: TL reloads the old TH; the new TH applies from the next overflow.
- `EN`=0 freezes TL and the prescale counter. `ST` is held, not cleared.
- Clearing `IE` drops `IRQ` the next cycle but keeps `ST`. Setting `IE` again re-raises `IRQ` if `ST`=1.
- `reset` asserted mid-count: everything returns to 0 asynchronously. Counting resumes only after software sets `EN`.

## Timing
- Write-to-effect: a register written at edge N shows its new value after edge N. The first tick after setting `EN` at edge N occurs at edge N+1.
- Overflow detected at edge N: TL = TH and `ST` = 1 after edge N; `IRQ` high in cycle N+1.
- `IRQ` falls the cycle after the acknowledging TCON write edge.
- Read latency 0: combinational from current register state. A read and a write to the same register in the same cycle return the old value.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - Adds PSC[15:0] at base+12 (read/write; reads zero-extended) and an internal 16-bit counter PC.
  - Expiry when PC == PSC; then PC <= 0, otherwise PC <= PC + 1 (only while `EN`).
  - PSC = 0 gives a tick every cycle.
  - Any PSC write clears PC.
- Undefined:
  - No PSC register or counter; base+12 is an unmapped word (reads 0, writes ignored).
  - Tick every cycle while `EN`.

## Test plan
- Reset during counting (TL=0x1234, `EN`=1), `reset` low mid-cycle → TL, TCON, `IRQ` read 0 immediately. TL stays 0 after release until `EN` is written.
- TH=TL=0xFFFF_FFFC, write TCON=3 at edge 0 → TL FD, FE, FF at edges 1–3. Edge 4: TL=0xFFFF_FFFC, `ST`=1, `IRQ`=1; TCON reads 7.
- With `IRQ` pending, write TCON=3 → `IRQ` low next cycle. The next overflow, 4 ticks later, re-raises it.
- Overflow edge coincides with TCON write 3 → `ST` stays 1, `IRQ` stays high. TL write 0x10 coinciding with a tick → TL=0x10, not 0x11.
- `TIMER_PRESCALE_EN`: PSC=2, TL=0, `EN`=1 → TL increments every 3rd cycle. Over 9 cycles TL reaches 3. Reads at base+12 return 2.
- Bus decode: read of 0x4000_0010 and unaligned 0x4000_0006 → `ReadData`=0; writes there leave all registers unchanged. `MemRd`=0 on a valid address → `ReadData`=0.
